// File: rtl/jtcontra_gfx_romarb.sv
// Round-robin arbiter sharing one SDRAM read slot between the gfx1/gfx2 ROM ports.
// Optional watchdog abort enabled by defining JTCONTRA_ROMARB_TIMEOUT_EN.
module jtcontra_gfx_romarb #(
    parameter int          AW    = 18,
    parameter int          DW    = 16,
    parameter logic [18:0] BASE1 = 19'h0,
    parameter logic [18:0] BASE2 = 19'h40000,
    parameter int          TOUT  = 255
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          gfx1_cs,
    input  logic [AW-1:0] gfx1_addr,
    output logic [DW-1:0] gfx1_data,
    output logic          gfx1_ok,
    input  logic          gfx2_cs,
    input  logic [AW-1:0] gfx2_addr,
    output logic [DW-1:0] gfx2_data,
    output logic          gfx2_ok,
    output logic          sdram_req,
    output logic [18:0]   sdram_addr,
    input  logic          sdram_ack,
    input  logic          sdram_rdy,
    input  logic [DW-1:0] sdram_din,
    output logic [7:0]    tout_cnt
);

    typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

    state_t        state_q, state_d;
    logic [1:0]    last_q, last_d;
    logic          req_q, req_d;
    logic [18:0]   saddr_q, saddr_d;
    logic [AW-1:0] lat_q, lat_d;
    logic [AW-1:0] tag1_q, tag1_d, tag2_q, tag2_d;
    logic          valid1_q, valid1_d, valid2_q, valid2_d;
    logic [DW-1:0] data1_q, data1_d, data2_q, data2_d;
    logic          hit1, hit2, pend1, pend2, g2, cap;

    assign hit1  = valid1_q && (gfx1_addr == tag1_q);
    assign hit2  = valid2_q && (gfx2_addr == tag2_q);
    assign pend1 = gfx1_cs && !hit1;
    assign pend2 = gfx2_cs && !hit2;

    assign gfx1_ok    = gfx1_cs && hit1;
    assign gfx2_ok    = gfx2_cs && hit2;
    assign gfx1_data  = data1_q;
    assign gfx2_data  = data2_q;
    assign sdram_req  = req_q;
    assign sdram_addr = saddr_q;

`ifdef JTCONTRA_ROMARB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d, tcnt_q, tcnt_d;
    assign tout_cnt = tcnt_q;
`else
    assign tout_cnt = '0;
`endif

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        req_d    = req_q;
        saddr_d  = saddr_q;
        lat_d    = lat_q;
        tag1_d   = tag1_q;
        tag2_d   = tag2_q;
        valid1_d = valid1_q;
        valid2_d = valid2_q;
        data1_d  = data1_q;
        data2_d  = data2_q;
        g2       = 1'b0;
        cap      = 1'b0;

        case (state_q)
            IDLE: begin
                if (pend1 || pend2) begin
                    // On a tie the port that did not win last time gets the slot
                    g2 = pend2 && (!pend1 || last_q == 2'd1);
                    if (g2) begin
                        saddr_d = 19'(gfx2_addr) + BASE2;
                        lat_d   = gfx2_addr;
                        last_d  = 2'd2;
                    end else begin
                        saddr_d = 19'(gfx1_addr) + BASE1;
                        lat_d   = gfx1_addr;
                        last_d  = 2'd1;
                    end
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (sdram_ack) begin
                    req_d = 1'b0;
                    if (sdram_rdy) begin
                        cap     = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (sdram_rdy) begin
                    cap     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Stored under the latched address, even if the port has moved on
        if (cap) begin
            if (last_q == 2'd2) begin
                data2_d  = sdram_din;
                tag2_d   = lat_q;
                valid2_d = 1'b1;
            end else begin
                data1_d  = sdram_din;
                tag1_d   = lat_q;
                valid1_d = 1'b1;
            end
        end

`ifdef JTCONTRA_ROMARB_TIMEOUT_EN
        tcnt_d = tcnt_q;
        cnt_d  = (state_q == IDLE) ? '0 : cnt_q + 8'd1;
        if (state_q != IDLE && !cap && cnt_q == 8'(TOUT - 1)) begin
            req_d   = 1'b0;
            state_d = IDLE;
            cnt_d   = '0;
            tcnt_d  = (tcnt_q == 8'hFF) ? tcnt_q : tcnt_q + 8'd1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            last_q   <= 2'd2;
            req_q    <= 1'b0;
            saddr_q  <= '0;
            lat_q    <= '0;
            tag1_q   <= '0;
            tag2_q   <= '0;
            valid1_q <= 1'b0;
            valid2_q <= 1'b0;
            data1_q  <= '0;
            data2_q  <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            req_q    <= req_d;
            saddr_q  <= saddr_d;
            lat_q    <= lat_d;
            tag1_q   <= tag1_d;
            tag2_q   <= tag2_d;
            valid1_q <= valid1_d;
            valid2_q <= valid2_d;
            data1_q  <= data1_d;
            data2_q  <= data2_d;
        end
    end

`ifdef JTCONTRA_ROMARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q  <= '0;
            tcnt_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            tcnt_q <= tcnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_jtcontra_gfx_romarb.sv
// Directed bench for jtcontra_gfx_romarb: SDRAM responder, per-cycle model compare,
// literal expectations; timeout scenario only when JTCONTRA_ROMARB_TIMEOUT_EN is defined.
module tb_jtcontra_gfx_romarb;
    localparam int          AW = 18;
    localparam int          DW = 16;
    localparam logic [18:0] B1 = 19'h0;
    localparam logic [18:0] B2 = 19'h40000;

    logic          clk = 1'b0;
    logic          rstn;
    logic          gfx1_cs, gfx2_cs;
    logic [AW-1:0] gfx1_addr, gfx2_addr;
    logic [DW-1:0] gfx1_data, gfx2_data;
    logic          gfx1_ok, gfx2_ok;
    logic          sdram_req, sdram_ack, sdram_rdy;
    logic [18:0]   sdram_addr;
    logic [DW-1:0] sdram_din;
    logic [7:0]    tout_cnt;

    always #5 clk = ~clk;

    jtcontra_gfx_romarb #(.AW(AW), .DW(DW), .BASE1(B1), .BASE2(B2), .TOUT(255)) dut (
        .clk(clk), .rstn(rstn),
        .gfx1_cs(gfx1_cs), .gfx1_addr(gfx1_addr), .gfx1_data(gfx1_data), .gfx1_ok(gfx1_ok),
        .gfx2_cs(gfx2_cs), .gfx2_addr(gfx2_addr), .gfx2_data(gfx2_data), .gfx2_ok(gfx2_ok),
        .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
        .sdram_rdy(sdram_rdy), .sdram_din(sdram_din), .tout_cnt(tout_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] rom(input logic [18:0] a);
        logic [15:0] r;
        r = a[15:0] ^ 16'hA5A5 ^ {a[18:16], 13'h0};
        return r;
    endfunction

    // Responder controls and bookkeeping
    int          lat = 4;
    bit          coincide = 0, no_rdy = 0, chk_gap = 0, seen_txn = 0;
    int          acks = 0, idle_n = 0, epoch = 0, caps = 0;
    bit          cap_flag = 0;
    logic [18:0] cap_addr = '0;
    int          cap_epoch = 0;
    int          grantq[$];

    // Model: what each port holds, as seen from the SDRAM side
    logic [18:0] mtag[1:2];
    bit          mvalid[1:2];

    initial begin
        logic [18:0] a;
        int ep;
        sdram_ack = 1'b0; sdram_rdy = 1'b0; sdram_din = '0;
        forever begin
            @(negedge clk);
            if (rstn && sdram_req) begin
                if (chk_gap && seen_txn) chk("req_gap", idle_n, 0);
                idle_n = 0;
                a  = sdram_addr;
                ep = epoch;
                acks++;
                grantq.push_back((a >= B2) ? 2 : 1);
                sdram_ack = 1'b1;
                if (coincide) begin
                    sdram_rdy = 1'b1; sdram_din = rom(a);
                    cap_addr = a; cap_epoch = ep; cap_flag = 1;
                end
                @(negedge clk);
                sdram_ack = 1'b0; sdram_rdy = 1'b0; cap_flag = 0;
                if (!coincide && !no_rdy) begin
                    repeat (lat - 1) @(negedge clk);
                    sdram_rdy = 1'b1; sdram_din = rom(a);
                    cap_addr = a; cap_epoch = ep; cap_flag = 1;
                    @(negedge clk);
                    sdram_rdy = 1'b0; cap_flag = 0;
                end
                seen_txn = 1;
            end else begin
                idle_n++;
            end
        end
    end

    // Per-cycle compare against the model
    initial begin
        int p;
        mvalid[1] = 0; mvalid[2] = 0; mtag[1] = '0; mtag[2] = '0;
        forever begin
            @(posedge clk);
            if (rstn && sdram_rdy && cap_flag && cap_epoch == epoch) begin
                p = (cap_addr >= B2) ? 2 : 1;
                mtag[p]   = cap_addr - ((p == 2) ? B2 : B1);
                mvalid[p] = 1;
                caps++;
            end
            #1;
            if (!rstn) begin
                mvalid[1] = 0; mvalid[2] = 0;
                chk("rst_ok1", gfx1_ok, 0);
                chk("rst_ok2", gfx2_ok, 0);
                chk("rst_data1", gfx1_data, 0);
                chk("rst_data2", gfx2_data, 0);
                chk("rst_req", sdram_req, 0);
                chk("rst_saddr", sdram_addr, 0);
            end else begin
                chk("model_ok1", gfx1_ok, gfx1_cs && mvalid[1] && mtag[1] == {1'b0, gfx1_addr});
                chk("model_ok2", gfx2_ok, gfx2_cs && mvalid[2] && mtag[2] == {1'b0, gfx2_addr});
                if (gfx1_ok) chk("model_data1", gfx1_data, rom(B1 + {1'b0, gfx1_addr}));
                if (gfx2_ok) chk("model_data2", gfx2_data, rom(B2 + {1'b0, gfx2_addr}));
`ifndef JTCONTRA_ROMARB_TIMEOUT_EN
                chk("tout_zero", tout_cnt, 0);
`endif
            end
        end
    end

    task automatic wait_ok(input int p, input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            ok = (p == 1) ? gfx1_ok : gfx2_ok;
            if (ok) break;
        end
        chk(name, ok, 1);
    endtask

    task automatic wait_req(input string name);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (sdram_req) break;
        end
        chk(name, sdram_req, 1);
    endtask

    task automatic wait_acks(input int a0, input string name);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (acks > a0) break;
        end
        chk(name, acks > a0, 1);
    endtask

    task automatic wait_caps(input int c0, input string name);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (caps > c0) break;
        end
        chk(name, caps > c0, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int a0, c0, n;
        rstn = 1'b1;
        gfx1_cs = 1'b0; gfx2_cs = 1'b0; gfx1_addr = '0; gfx2_addr = '0;
        #1 rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        // Single fetch on port 1
        @(negedge clk); gfx1_cs = 1'b1; gfx1_addr = 18'h00010;
        @(posedge clk); #1;
        chk("t1_req_1clk", sdram_req, 1);
        chk("t1_saddr", sdram_addr, 19'h00010);
        wait_ok(1, "t1_ok");
        chk("t1_data", gfx1_data, 16'hA5B5);
        repeat (20) @(posedge clk);
        chk("t1_single_req", acks, 1);

        // Port 2 with its base offset; port 1 stays valid
        @(negedge clk); gfx2_cs = 1'b1; gfx2_addr = 18'h00020;
        @(posedge clk); #1;
        chk("t2_req", sdram_req, 1);
        chk("t2_saddr", sdram_addr, 19'h40020);
        wait_ok(2, "t2_ok");
        chk("t2_data", gfx2_data, 16'h2585);
        chk("t2_gfx1_ok", gfx1_ok, 1);
        chk("t2_gfx1_data", gfx1_data, 16'hA5B5);

        // Both ports miss every cycle: strict alternation, back-to-back requests
        @(negedge clk);
        grantq.delete(); seen_txn = 0; chk_gap = 1;
        for (int i = 0; i < 400 && grantq.size() < 8; i++) begin
            gfx1_addr = 18'h00100 + 18'(i);
            gfx2_addr = 18'h00200 + 18'(i);
            @(negedge clk);
        end
        chk_gap = 0;
        chk("t3_eight_grants", grantq.size() >= 8, 1);
        for (int i = 0; i < 8 && i < grantq.size(); i++)
            chk($sformatf("t3_grant%0d", i), grantq[i], (i % 2 == 0) ? 1 : 2);
        gfx2_cs = 1'b0;
        repeat (40) @(negedge clk);

        // Address change while the fetch is in DATA
        a0 = acks; c0 = caps;
        gfx1_addr = 18'h00010;
        wait_acks(a0, "t4_ack");
        @(negedge clk); gfx1_addr = 18'h00011;
        wait_caps(c0, "t4_cap");
        chk("t4_ok_low", gfx1_ok, 0);
        chk("t4_stored_tag", mtag[1], 19'h00010);
        wait_req("t4_rereq");
        chk("t4_saddr", sdram_addr, 19'h00011);
        wait_ok(1, "t4_ok");
        chk("t4_data", gfx1_data, 16'hA5B4);

        // ack and rdy in the same cycle
        repeat (5) @(negedge clk);
        coincide = 1; c0 = caps;
        gfx2_cs = 1'b1; gfx2_addr = 18'h00030;
        wait_caps(c0, "t5_cap");
        chk("t5_ok", gfx2_ok, 1);
        chk("t5_data", gfx2_data, 16'h2595);
        chk("t5_req_low", sdram_req, 0);
        @(negedge clk); coincide = 0; gfx2_addr = 18'h00031;
        @(posedge clk); #1;
        chk("t5_idle_reissue", sdram_req, 1);
        wait_ok(2, "t5_ok2");
        chk("t5_data2", gfx2_data, 16'h2594);

        // Stray ack/rdy while idle must be ignored
        repeat (3) @(negedge clk);
        sdram_ack = 1'b1; sdram_rdy = 1'b1; sdram_din = 16'hDEAD;
        @(negedge clk);
        sdram_ack = 1'b0; sdram_rdy = 1'b0;
        @(posedge clk); #1;
        chk("t6_data1", gfx1_data, 16'hA5B4);
        chk("t6_data2", gfx2_data, 16'h2594);
        chk("t6_req", sdram_req, 0);

        // Asynchronous reset in DATA; the late rdy must not be stored
        @(negedge clk); a0 = acks;
        gfx1_addr = 18'h00050;
        wait_acks(a0, "t7_ack");
        @(negedge clk); #2;
        rstn = 1'b0; epoch++;
        #1;
        chk("t7_rst_req", sdram_req, 0);
        chk("t7_rst_saddr", sdram_addr, 0);
        chk("t7_rst_ok1", gfx1_ok, 0);
        chk("t7_rst_ok2", gfx2_ok, 0);
        chk("t7_rst_data1", gfx1_data, 0);
        chk("t7_rst_data2", gfx2_data, 0);
        chk("t7_rst_tout", tout_cnt, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        wait_ok(1, "t7_refetch_ok");
        chk("t7_data", gfx1_data, 16'hA5F5);

`ifdef JTCONTRA_ROMARB_TIMEOUT_EN
        // SDRAM never returns data: abort after 255 cycles, then retry
        repeat (10) @(negedge clk);
        no_rdy = 1;
        gfx2_addr = 18'h00060;
        wait_req("t8_req");
        n = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1; n++;
            if (tout_cnt != 0) break;
        end
        no_rdy = 0;
        chk("t8_abort_cycles", n, 255);
        chk("t8_tout_cnt", tout_cnt, 1);
        chk("t8_abort_req_low", sdram_req, 0);
        @(posedge clk); #1;
        chk("t8_reissue", sdram_req, 1);
        chk("t8_saddr", sdram_addr, 19'h40060);
        wait_ok(2, "t8_ok");
        chk("t8_data", gfx2_data, 16'h25C5);
`else
        n = 0;
`endif

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
